// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard sources and debug halt request
// in one direction, stall/flush controls and halt acknowledge in the other.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_jump;
  logic       exe_is_load;
  logic       exe_reg_write;
  logic [4:0] exe_num_write;
  logic       mem_branch_taken;
  logic       halt_req;
  logic       pc_stall;
  logic       if2id_stall;
  logic       if2id_flush;
  logic       id2exe_flush;
  logic       exe2mem_flush;
  logic       halt_ack;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           exe_is_load, exe_reg_write, exe_num_write, mem_branch_taken, halt_req,
    input  pc_stall, if2id_stall, if2id_flush, id2exe_flush, exe2mem_flush, halt_ack
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           exe_is_load, exe_reg_write, exe_num_write, mem_branch_taken, halt_req,
    output pc_stall, if2id_stall, if2id_flush, id2exe_flush, exe2mem_flush, halt_ack
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use stalls, branch (MEM)
// and jump (ID) flushes, debug halt/drain handshake and saturating event counters.
module hazard_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_ctrl_if.slave         hz,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [0:0]           state_r;
  logic [0:0]           state_nxt_s;
  logic [DRAIN_W-1:0]   drain_r;
  logic [DRAIN_W-1:0]   drain_nxt_s;
  logic                 halt_ack_r;
  logic [CNT_WIDTH-1:0] stall_count_r;
  logic [CNT_WIDTH-1:0] flush_count_r;
  logic                 lu_s;
  logic                 any_flush_s;
  logic                 pc_stall_s;
  logic                 if2id_stall_s;
  logic                 if2id_flush_s;
  logic                 id2exe_flush_s;
  logic                 exe2mem_flush_s;

  assign lu_s = hz.exe_is_load && hz.exe_reg_write && (hz.exe_num_write != 5'd0) &&
                ((hz.id_use_rs && (hz.id_rs == hz.exe_num_write)) ||
                 (hz.id_use_rt && (hz.id_rt == hz.exe_num_write)));

  // Stall/flush controls, combinational so the pipeline registers act on them this edge
  always_comb begin
    pc_stall_s      = 1'b0;
    if2id_stall_s   = 1'b0;
    if2id_flush_s   = 1'b0;
    id2exe_flush_s  = 1'b0;
    exe2mem_flush_s = 1'b0;
    if (!reset) begin
      pc_stall_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.mem_branch_taken) begin
            if2id_flush_s   = 1'b1;
            id2exe_flush_s  = 1'b1;
            exe2mem_flush_s = 1'b1;
          end else if (lu_s) begin
            pc_stall_s     = 1'b1;
            if2id_stall_s  = 1'b1;
            id2exe_flush_s = 1'b1;
          end else if (hz.id_jump) begin
            if2id_flush_s = 1'b1;
          end else begin
            pc_stall_s = 1'b0;
          end
        end
        HALT: begin
          // An older branch still draining through MEM overrides the freeze for one cycle
          if (hz.mem_branch_taken) begin
            if2id_flush_s   = 1'b1;
            id2exe_flush_s  = 1'b1;
            exe2mem_flush_s = 1'b1;
          end else begin
            pc_stall_s     = 1'b1;
            if2id_stall_s  = 1'b1;
            id2exe_flush_s = 1'b1;
          end
        end
        default: begin
          pc_stall_s = 1'b0;
        end
      endcase
    end
  end

  // Next state and drain counter
  always_comb begin
    state_nxt_s = state_r;
    drain_nxt_s = drain_r;
    case (state_r)
      RUN: begin
        drain_nxt_s = {DRAIN_W{1'b0}};
        if (hz.halt_req && !hz.mem_branch_taken && !lu_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (!hz.halt_req) begin
          state_nxt_s = RUN;
          drain_nxt_s = {DRAIN_W{1'b0}};
        end else if (hz.mem_branch_taken) begin
          drain_nxt_s = {DRAIN_W{1'b0}};
        end else if (drain_r != DRAIN_MAX) begin
          drain_nxt_s = drain_r + DRAIN_W'(1);
        end else begin
          drain_nxt_s = drain_r;
        end
      end
      default: begin
        state_nxt_s = RUN;
        drain_nxt_s = {DRAIN_W{1'b0}};
      end
    endcase
  end

  assign any_flush_s = if2id_flush_s || id2exe_flush_s || exe2mem_flush_s;

  // State, drain, halt acknowledge and saturating event counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= RUN;
      drain_r       <= {DRAIN_W{1'b0}};
      halt_ack_r    <= 1'b0;
      stall_count_r <= {CNT_WIDTH{1'b0}};
      flush_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      drain_r    <= drain_nxt_s;
      halt_ack_r <= (state_nxt_s == HALT) && (drain_nxt_s == DRAIN_MAX);
      if (pc_stall_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_WIDTH'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (any_flush_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + CNT_WIDTH'(1);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign hz.pc_stall      = pc_stall_s;
  assign hz.if2id_stall   = if2id_stall_s;
  assign hz.if2id_flush   = if2id_flush_s;
  assign hz.id2exe_flush  = id2exe_flush_s;
  assign hz.exe2mem_flush = exe2mem_flush_s;
  assign hz.halt_ack      = halt_ack_r;
  assign stall_count      = stall_count_r;
  assign flush_count      = flush_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default 32-bit counter build and a 4-bit
// counter build share the same stimulus; ctl packs {pc_stall,if2id_stall,if2id_flush,id2exe_flush,exe2mem_flush}.
module tb_hazard_ctrl;
  logic       clock;
  logic       reset;
  logic [4:0] id_rs, id_rt, exe_num_write;
  logic       id_use_rs, id_use_rt, id_jump, exe_is_load, exe_reg_write, mem_branch_taken, halt_req;
  logic [31:0] sc32, fc32;
  logic [3:0]  sc4, fc4;
  int checks = 0;
  int fails  = 0;

  hazard_ctrl_if hif ();
  hazard_ctrl_if hif4 ();

  assign hif.id_rs = id_rs;                       assign hif4.id_rs = id_rs;
  assign hif.id_rt = id_rt;                       assign hif4.id_rt = id_rt;
  assign hif.id_use_rs = id_use_rs;               assign hif4.id_use_rs = id_use_rs;
  assign hif.id_use_rt = id_use_rt;               assign hif4.id_use_rt = id_use_rt;
  assign hif.id_jump = id_jump;                   assign hif4.id_jump = id_jump;
  assign hif.exe_is_load = exe_is_load;           assign hif4.exe_is_load = exe_is_load;
  assign hif.exe_reg_write = exe_reg_write;       assign hif4.exe_reg_write = exe_reg_write;
  assign hif.exe_num_write = exe_num_write;       assign hif4.exe_num_write = exe_num_write;
  assign hif.mem_branch_taken = mem_branch_taken; assign hif4.mem_branch_taken = mem_branch_taken;
  assign hif.halt_req = halt_req;                 assign hif4.halt_req = halt_req;

  hazard_ctrl dut (.clock(clock), .reset(reset), .hz(hif), .stall_count(sc32), .flush_count(fc32));
  hazard_ctrl #(.CNT_WIDTH(4), .DRAIN_CYCLES(3)) dut4 (.clock(clock), .reset(reset), .hz(hif4),
                                                       .stall_count(sc4), .flush_count(fc4));

  wire [4:0] ctl  = {hif.pc_stall, hif.if2id_stall, hif.if2id_flush, hif.id2exe_flush, hif.exe2mem_flush};
  wire [4:0] ctl4 = {hif4.pc_stall, hif4.if2id_stall, hif4.if2id_flush, hif4.id2exe_flush, hif4.exe2mem_flush};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary line in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; exe_num_write = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_jump = 1'b0; exe_is_load = 1'b0;
    exe_reg_write = 1'b0; mem_branch_taken = 1'b0; halt_req = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released and counters at zero.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    exe_is_load = 1'b1; exe_reg_write = 1'b1; exe_num_write = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    set_load_use(5'd7);
    halt_req = 1'b1; id_jump = 1'b1; mem_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL rst_ctl: got %b expected %b", ctl, 5'b00000); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (hif.halt_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b expected 0", hif.halt_ack); end
    checks++; if (sc32 !== 32'd0 || fc32 !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", sc32, fc32); end
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    #1;
    checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL lu_ctl: got %b expected %b", ctl, 5'b11010); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd1 || fc32 !== 32'd1) begin fails++; $display("FAIL lu_cnt: got %0d/%0d expected 1/1", sc32, fc32); end
    @(negedge clock);
    exe_is_load = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL lu_after: got %b expected %b", ctl, 5'b00000); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd1 || fc32 !== 32'd1) begin fails++; $display("FAIL lu_cnt2: got %0d/%0d expected 1/1", sc32, fc32); end
  endtask

  task automatic test_load_zero();
    apply_reset();
    exe_is_load = 1'b1; exe_reg_write = 1'b1; exe_num_write = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL lz_ctl: got %b expected %b", ctl, 5'b00000); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd0) begin fails++; $display("FAIL lz_cnt: got %0d expected 0", sc32); end
    @(negedge clock);
    exe_num_write = 5'd9; id_rs = 5'd9; id_rt = 5'd9; id_use_rs = 1'b0; id_use_rt = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL lz_nouse: got %b expected %b", ctl, 5'b00000); end
    id_use_rt = 1'b1;
    #1;
    checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL lz_rt: got %b expected %b", ctl, 5'b11010); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd1) begin fails++; $display("FAIL lz_cnt2: got %0d expected 1", sc32); end
  endtask

  task automatic test_branch();
    apply_reset();
    set_load_use(5'd3);
    id_jump = 1'b1; mem_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00111) begin fails++; $display("FAIL br_ctl: got %b expected %b", ctl, 5'b00111); end
    @(posedge clock); #1;
    checks++; if (fc32 !== 32'd1 || sc32 !== 32'd0) begin fails++; $display("FAIL br_cnt: got %0d/%0d expected 0/1", sc32, fc32); end
  endtask

  task automatic test_lu_jump();
    apply_reset();
    set_load_use(5'd12);
    id_jump = 1'b1;
    #1;
    checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL luj_ctl: got %b expected %b", ctl, 5'b11010); end
    @(negedge clock);
    exe_is_load = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00100) begin fails++; $display("FAIL luj_jump: got %b expected %b", ctl, 5'b00100); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd1 || fc32 !== 32'd2) begin fails++; $display("FAIL luj_cnt: got %0d/%0d expected 1/2", sc32, fc32); end
  endtask

  task automatic test_halt_resume();
    apply_reset();
    halt_req = 1'b1; id_jump = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00100) begin fails++; $display("FAIL hr_entry: got %b expected %b", ctl, 5'b00100); end
    @(posedge clock); #1;
    checks++; if (hif.halt_ack !== 1'b0) begin fails++; $display("FAIL hr_ack0: got %b expected 0", hif.halt_ack); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      id_jump = 1'b0;
      #1;
      checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL hr_ctl%0d: got %b expected %b", i, ctl, 5'b11010); end
      @(posedge clock); #1;
      checks++; if (hif.halt_ack !== (i >= 3)) begin fails++; $display("FAIL hr_ack%0d: got %b expected %b", i, hif.halt_ack, (i >= 3)); end
    end
    @(negedge clock);
    halt_req = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL hr_last: got %b expected %b", ctl, 5'b11010); end
    @(posedge clock); #1;
    checks++; if (hif.halt_ack !== 1'b0) begin fails++; $display("FAIL hr_ackdrop: got %b expected 0", hif.halt_ack); end
    checks++; if (sc32 !== 32'd5 || fc32 !== 32'd6) begin fails++; $display("FAIL hr_cnt: got %0d/%0d expected 5/6", sc32, fc32); end
    @(negedge clock); #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL hr_resume: got %b expected %b", ctl, 5'b00000); end
  endtask

  task automatic test_halt_branch();
    apply_reset();
    halt_req = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (hif.halt_ack !== 1'b1) begin fails++; $display("FAIL hb_ack: got %b expected 1", hif.halt_ack); end
    @(negedge clock);
    mem_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00111) begin fails++; $display("FAIL hb_ctl: got %b expected %b", ctl, 5'b00111); end
    @(posedge clock); #1;
    checks++; if (hif.halt_ack !== 1'b0) begin fails++; $display("FAIL hb_restart: got %b expected 0", hif.halt_ack); end
    @(negedge clock);
    mem_branch_taken = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11010) begin fails++; $display("FAIL hb_refreeze: got %b expected %b", ctl, 5'b11010); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (hif.halt_ack !== 1'b0) begin fails++; $display("FAIL hb_ack2: got %b expected 0", hif.halt_ack); end
    @(posedge clock); #1;
    checks++; if (hif.halt_ack !== 1'b1) begin fails++; $display("FAIL hb_ack3: got %b expected 1", hif.halt_ack); end
    checks++; if (sc32 !== 32'd6 || fc32 !== 32'd7) begin fails++; $display("FAIL hb_cnt: got %0d/%0d expected 6/7", sc32, fc32); end
  endtask

  task automatic test_saturation_reset();
    apply_reset();
    halt_req = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    checks++; if (sc4 !== 4'd15 || fc4 !== 4'd15) begin fails++; $display("FAIL sat4: got %0d/%0d expected 15/15", sc4, fc4); end
    checks++; if (sc32 !== 32'd19 || fc32 !== 32'd19) begin fails++; $display("FAIL sat32: got %0d/%0d expected 19/19", sc32, fc32); end
    checks++; if (hif4.halt_ack !== 1'b1) begin fails++; $display("FAIL sat_ack: got %b expected 1", hif4.halt_ack); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00000 || ctl4 !== 5'b00000) begin fails++; $display("FAIL midrst_ctl: got %b/%b expected 00000", ctl, ctl4); end
    @(posedge clock); #1;
    checks++; if (hif.halt_ack !== 1'b0 || hif4.halt_ack !== 1'b0) begin fails++; $display("FAIL midrst_ack: got %b/%b expected 0/0", hif.halt_ack, hif4.halt_ack); end
    checks++; if (sc32 !== 32'd0 || sc4 !== 4'd0 || fc4 !== 4'd0) begin fails++; $display("FAIL midrst_cnt: got %0d/%0d/%0d expected 0/0/0", sc32, sc4, fc4); end
    @(negedge clock);
    reset = 1'b1; halt_req = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL midrst_run: got %b expected %b", ctl, 5'b00000); end
    @(posedge clock); #1;
    checks++; if (sc32 !== 32'd0) begin fails++; $display("FAIL midrst_nostall: got %0d expected 0", sc32); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_zero();
    test_branch();
    test_lu_jump();
    test_halt_resume();
    test_halt_branch();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
